// File: rtl/tohost_exit_monitor.sv
// tohost_exit_monitor
// Snoops the HTIF tohost write channel of the SoC and turns it into a sticky
// pass/fail verdict for the harness. It also forwards console characters through
// a one-entry buffer and flags a hang when no progress is seen for too long.
module tohost_exit_monitor #(
  parameter int                ADDR_W          = 32,
  parameter int                DATA_W          = 64,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR     = 32'h80001000,
  parameter int                HOLDOFF_CYCLES  = 8,
  parameter int                WATCHDOG_CYCLES = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic                heartbeat,
  output logic                char_valid,
  input  logic                char_ready,
  output logic [7:0]          char_data,
  output logic                success,
  output logic                failure,
  output logic [31:0]         exit_code,
  output logic [1:0]          fail_reason
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0]  REASON_NONE  = 2'd0;
  localparam logic [1:0]  REASON_EXIT  = 2'd1;
  localparam logic [1:0]  REASON_HANG  = 2'd2;
  localparam logic [1:0]  REASON_BAD   = 2'd3;
  localparam logic [31:0] HOLDOFF_INIT = 32'(HOLDOFF_CYCLES);
  localparam logic [31:0] WD_LAST      = 32'(WATCHDOG_CYCLES - 1);
  localparam bit          WD_EN        = (WATCHDOG_CYCLES > 0);

  // Idle counter increment that sticks at all-ones instead of wrapping, so a
  // very long idle stretch can never alias back to a small count.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t      state_q, state_d;
  logic        char_valid_q, char_valid_d;
  logic [7:0]  char_data_q, char_data_d;
  logic        pass_q, pass_d;
  logic [31:0] code_q, code_d;
  logic [1:0]  reason_q, reason_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] idle_q, idle_d;

  logic        wr_fire;
  logic        hit;
  logic [7:0]  dev;
  logic [7:0]  cmd;
  logic [31:0] exit_field;
  logic        is_putchar;
  logic        is_exit;
  logic        is_bad;
  logic        char_fire;
  logic        wd_clear;
  logic        wd_expire;

  // A full console buffer is the only thing that ever back-pressures writes.
  assign wr_fire    = wr_valid && !char_valid_q;
  assign hit        = wr_fire && (wr_addr == TOHOST_ADDR) && (wr_strb[7:0] == 8'hFF);
  assign dev        = wr_data[63:56];
  assign cmd        = wr_data[55:48];
  assign exit_field = wr_data[32:1];
  assign is_putchar = hit && (dev == 8'd1) && (cmd == 8'd1);
  assign is_exit    = hit && (dev == 8'd0) && wr_data[0];
  // Anything nonzero that is neither putchar nor exit; zero is a tohost clear.
  assign is_bad     = hit && !is_putchar && !is_exit && (|wr_data);
  assign char_fire  = char_valid_q && char_ready;
  assign wd_clear   = heartbeat || wr_fire;
  assign wd_expire  = WD_EN && (idle_q == WD_LAST) && !wd_clear;

  // Next-state logic: console buffer, verdict FSM, drain and watchdog counters.
  always_comb begin
    state_d      = state_q;
    char_valid_d = char_valid_q;
    char_data_d  = char_data_q;
    pass_d       = pass_q;
    code_d       = code_q;
    reason_d     = reason_q;
    cnt_d        = cnt_q;
    idle_d       = idle_q;

    // putchar can only land while the buffer is empty, so it never races a handshake
    if (is_putchar) begin
      char_valid_d = 1'b1;
      char_data_d  = wr_data[7:0];
    end else if (char_fire) begin
      char_valid_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        // an exit/malformed hit takes priority over a same-cycle watchdog expiry
        if (is_exit || is_bad) begin
          state_d  = ST_DRAIN;
          cnt_d    = HOLDOFF_INIT;
          pass_d   = is_exit && (exit_field == 32'd0);
          code_d   = is_exit ? exit_field : 32'd0;
          if (is_bad) begin
            reason_d = REASON_BAD;
          end else if (exit_field == 32'd0) begin
            reason_d = REASON_NONE;
          end else begin
            reason_d = REASON_EXIT;
          end
        end else if (wd_expire) begin
          state_d  = ST_DONE;
          pass_d   = 1'b0;
          code_d   = 32'd0;
          reason_d = REASON_HANG;
        end
        idle_d = wd_clear ? 32'd0 : sat_inc(idle_q);
      end
      ST_DRAIN: begin
        // hold off the verdict until the holdoff expires and the console is flushed
        if ((cnt_q == 32'd0) && !char_valid_q) begin
          state_d = ST_DONE;
        end else if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State register with synchronous active-high reset back to RUN, buffer empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      char_valid_q <= 1'b0;
      char_data_q  <= 8'd0;
      pass_q       <= 1'b0;
      code_q       <= 32'd0;
      reason_q     <= REASON_NONE;
      cnt_q        <= 32'd0;
      idle_q       <= 32'd0;
    end else begin
      state_q      <= state_d;
      char_valid_q <= char_valid_d;
      char_data_q  <= char_data_d;
      pass_q       <= pass_d;
      code_q       <= code_d;
      reason_q     <= reason_d;
      cnt_q        <= cnt_d;
      idle_q       <= idle_d;
    end
  end

  assign wr_ready    = !char_valid_q;
  assign char_valid  = char_valid_q;
  assign char_data   = char_data_q;
  assign success     = (state_q == ST_DONE) && pass_q;
  assign failure     = (state_q == ST_DONE) && !pass_q;
  assign exit_code   = code_q;
  assign fail_reason = reason_q;

endmodule

// File: tb/tb_tohost_exit_monitor.sv
// Bench for tohost_exit_monitor: directed HTIF traffic, a cycle-level reference
// model of the tohost rules, and hand-computed spot checks at key cycles.
module tb_tohost_exit_monitor;

  localparam int          HOLD = 4;
  localparam int          WD   = 100;
  localparam logic [31:0] TH   = 32'h80001000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_addr = 32'd0;
  logic [63:0] wr_data = 64'd0;
  logic [7:0]  wr_strb = 8'd0;
  logic        heartbeat = 1'b1;
  logic        char_valid;
  logic        char_ready = 1'b1;
  logic [7:0]  char_data;
  logic        success;
  logic        failure;
  logic [31:0] exit_code;
  logic [1:0]  fail_reason;

  tohost_exit_monitor #(
    .ADDR_W(32), .DATA_W(64), .TOHOST_ADDR(TH),
    .HOLDOFF_CYCLES(HOLD), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_strb(wr_strb), .heartbeat(heartbeat),
    .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
    .success(success), .failure(failure), .exit_code(exit_code),
    .fail_reason(fail_reason)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the verdict is decided by the first exit/malformed write or
  // by the idle limit; a decided exit becomes visible HOLD+1 cycles later, and
  // not before the console queue has drained.
  bit          m_on = 1'b0;
  byte unsigned m_q[$];
  bit          m_decided, m_done, m_pass;
  logic [31:0] m_code;
  logic [1:0]  m_reason;
  int          m_left, m_idle;
  bit          m_empty, m_acc, m_hit, m_clr;
  logic [63:0] m_d;

  always @(posedge clock) begin
    if (reset) begin
      m_on = 1'b1; m_q.delete(); m_decided = 0; m_done = 0; m_pass = 0;
      m_code = 32'd0; m_reason = 2'd0; m_left = 0; m_idle = 0;
    end else if (m_on) begin
      m_empty = (m_q.size() == 0);
      m_acc   = wr_valid && m_empty;
      m_d     = wr_data;
      m_hit   = m_acc && (wr_addr == TH) && (wr_strb == 8'hFF);
      m_clr   = heartbeat || m_acc;
      if (!m_empty && char_ready) void'(m_q.pop_front());
      if (m_hit && m_d[63:48] == 16'h0101) m_q.push_back(m_d[7:0]);
      if (!m_decided) begin
        if (m_hit && m_d[63:56] == 8'd0 && m_d[0]) begin
          m_decided = 1; m_code = m_d[32:1]; m_pass = (m_code == 32'd0);
          m_reason = m_pass ? 2'd0 : 2'd1; m_left = HOLD;
        end else if (m_hit && m_d != 64'd0 && m_d[63:48] != 16'h0101) begin
          m_decided = 1; m_code = 32'd0; m_pass = 0; m_reason = 2'd3; m_left = HOLD;
        end else if (m_idle == WD - 1 && !m_clr) begin
          m_decided = 1; m_done = 1; m_code = 32'd0; m_pass = 0; m_reason = 2'd2;
        end
        m_idle = m_clr ? 0 : m_idle + 1;
      end else if (!m_done) begin
        if (m_left == 0 && m_empty) m_done = 1;
        else if (m_left > 0) m_left--;
      end
    end
    #1;
    if (m_on) begin
      chk("m_wr_ready", wr_ready, m_q.size() == 0);
      chk("m_char_valid", char_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("m_char_data", char_data, m_q[0]);
      chk("m_success", success, m_done && m_pass);
      chk("m_failure", failure, m_done && !m_pass);
      chk("m_exit_code", exit_code, m_decided ? m_code : 32'd0);
      chk("m_fail_reason", fail_reason, m_decided ? m_reason : 2'd0);
    end
  end

  // Leaves the bench at the falling edge of the first cycle with reset low.
  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge one cycle after acceptance.
  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    wr_addr = a; wr_data = d; wr_strb = s; wr_valid = 1'b1;
    for (int i = 0; i < 64 && !wr_ready; i++) @(negedge clock);
    if (!wr_ready) begin
      checks++; errors++;
      $display("FAIL write_accept actual=stalled required=accepted at t=%0t", $time);
    end
    @(negedge clock);
    wr_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    heartbeat = 1'b1; char_ready = 1'b1;
    do_reset(3);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_char_valid", char_valid, 0);
    chk("rst_success", success, 0);
    chk("rst_failure", failure, 0);
    chk("rst_exit_code", exit_code, 0);
    chk("rst_fail_reason", fail_reason, 0);

    // exit 0 accepted at cycle 10, success from cycle 16
    repeat (10) @(negedge clock);
    do_write(TH, 64'h1, 8'hFF);
    chk("t1_success_drain", success, 0);
    repeat (4) @(negedge clock);
    chk("t1_success_n5", success, 0);
    @(negedge clock);
    chk("t1_success_n6", success, 1);
    chk("t1_failure", failure, 0);
    chk("t1_exit_code", exit_code, 0);
    chk("t1_fail_reason", fail_reason, 0);
    repeat (3) @(negedge clock);
    chk("t1_sticky", success, 1);

    // exit 3 -> failure
    do_reset(2);
    do_write(TH, 64'h7, 8'hFF);
    chk("t2_code_drain", exit_code, 3);
    repeat (4) @(negedge clock);
    chk("t2_failure_n5", failure, 0);
    @(negedge clock);
    chk("t2_failure_n6", failure, 1);
    chk("t2_fail_reason", fail_reason, 1);
    chk("t2_success", success, 0);

    // putchar held against a stalled sink
    do_reset(2);
    char_ready = 1'b0;
    do_write(TH, 64'h0101_0000_0000_0041, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      chk("t3_char_valid", char_valid, 1);
      chk("t3_char_data", char_data, 8'h41);
      chk("t3_wr_ready", wr_ready, 0);
      @(negedge clock);
    end
    char_ready = 1'b1;
    @(negedge clock);
    char_ready = 1'b0;
    chk("t3_char_empty", char_valid, 0);
    chk("t3_wr_ready_back", wr_ready, 1);

    // non-hits and tohost clear are ignored; then a malformed command
    do_write(TH + 32'h8, 64'h1, 8'hFF);
    do_write(TH, 64'h1, 8'h0F);
    do_write(TH, 64'h0, 8'hFF);
    repeat (8) @(negedge clock);
    chk("t5_nonhit_success", success, 0);
    chk("t5_nonhit_failure", failure, 0);
    do_write(TH, 64'h10, 8'hFF);
    repeat (5) @(negedge clock);
    chk("t5_bad_failure", failure, 1);
    chk("t5_bad_reason", fail_reason, 3);
    chk("t5_bad_code", exit_code, 0);

    // pending console char holds the verdict back
    do_reset(2);
    do_write(TH, 64'h1, 8'hFF);
    do_write(TH, 64'h0101_0000_0000_005A, 8'hFF);
    repeat (8) @(negedge clock);
    chk("t7_blocked_success", success, 0);
    chk("t7_blocked_char", char_valid, 1);
    char_ready = 1'b1;
    @(negedge clock);
    char_ready = 1'b0;
    @(negedge clock);
    chk("t7_success", success, 1);

    // reset during DRAIN with a pending char
    do_reset(2);
    do_write(TH, 64'h1, 8'hFF);
    do_write(TH, 64'h0101_0000_0000_0033, 8'hFF);
    do_reset(1);
    chk("t6_wr_ready", wr_ready, 1);
    chk("t6_char_valid", char_valid, 0);
    chk("t6_char_data", char_data, 0);
    chk("t6_success", success, 0);
    chk("t6_failure", failure, 0);
    chk("t6_exit_code", exit_code, 0);
    chk("t6_fail_reason", fail_reason, 0);
    do_write(TH, 64'h1, 8'hFF);
    repeat (5) @(negedge clock);
    chk("t6_run_success", success, 1);

    // watchdog expiry with no heartbeat
    heartbeat = 1'b0;
    do_reset(2);
    repeat (99) @(negedge clock);
    chk("t4_failure_c99", failure, 0);
    @(negedge clock);
    chk("t4_failure_c100", failure, 1);
    chk("t4_fail_reason", fail_reason, 2);
    chk("t4_success", success, 0);

    // heartbeat every 50 cycles keeps it alive
    do_reset(2);
    for (int i = 0; i < 300; i++) begin
      heartbeat = ((i % 50) == 49);
      @(negedge clock);
    end
    heartbeat = 1'b0;
    chk("t4_hb_failure", failure, 0);

    // exit lands on the expiry cycle; a later exit is ignored
    do_reset(2);
    repeat (99) @(negedge clock);
    wr_addr = TH; wr_data = 64'h1; wr_strb = 8'hFF; wr_valid = 1'b1;
    @(negedge clock);
    wr_valid = 1'b0;
    chk("t5_race_failure", failure, 0);
    chk("t5_race_reason", fail_reason, 0);
    do_write(TH, 64'h3, 8'hFF);
    repeat (4) @(negedge clock);
    chk("t5_race_success", success, 1);
    chk("t5_race_code", exit_code, 0);
    chk("t5_race_nofail", failure, 0);
    heartbeat = 1'b1;
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
